adder_stim_checker: RTL

- Hardware stimulus and checker: the driving end of the 4-bit full-adder operand interface (A, B, Cin in; S, Cout back).
- Sweeps every {A,B,Cin} combination into an external adder under test and samples its S/Cout after a programmable settle time.
- Compares each result against an internal golden sum; reports error count, first failing vector and pass/fail.
- Sits beside the structural adder in on-board self-test builds, replacing the simulation-only stimulus process.

---
 rtl/adder_stim_checker_pkg.sv | 25 ++
 rtl/adder_stim_checker_ref.sv | 22 ++
 rtl/adder_stim_checker.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/adder_stim_checker_pkg.sv
// Shared definitions for the adder stimulus/checker block.
// Holds the default parameter values, the width of the packed {A,B,Cin}
// vector, and the checker FSM state encoding.
package adder_stim_checker_pkg;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_SETTLE = 2;
    localparam int DEF_ERR_W  = 10;

    // Width of the {A,B,Cin} vector at default WIDTH.
    localparam int VEC_W = 2 * DEF_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Width of the {A,B,Cin} vector for an arbitrary operand width.
    function automatic int vec_width(input int width);
        return 2 * width + 1;
    endfunction

endpackage

// File: rtl/adder_stim_checker_ref.sv
// adder_ref_model: purely combinational golden full adder.
// Ports:
//   A, B      WIDTH-bit operands
//   Cin       carry-in
//   S_ref     WIDTH-bit golden sum
//   Cout_ref  golden carry-out
module adder_ref_model #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S_ref,
    output logic             Cout_ref
);

    // Sum is formed at WIDTH+1 bits so the carry-out falls out of the MSB.
    always_comb begin
        {Cout_ref, S_ref} = (WIDTH+1)'(A) + (WIDTH+1)'(B) + (WIDTH+1)'(Cin);
    end

endmodule

// File: rtl/adder_stim_checker.sv
// adder_stim_checker: drives every {A,B,Cin} combination into an external
// adder, samples its S/Cout after SETTLE cycles and compares against the
// internal golden model. Reports a saturating error count, the first failing
// vector and an overall pass flag.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             begin a sweep (accepted only in IDLE or DONE)
//   A, B, Cin         operands driven to the adder under test
//   S, Cout           result returned by the adder under test
//   busy              sweep in progress
//   done              sweep complete, held until the next start
//   pass              done with zero mismatches
//   err_count         saturating mismatch count
//   first_fail_valid  a mismatch has been captured
//   first_fail_vec    {A,B,Cin} of the first mismatch
module adder_stim_checker
    import adder_stim_checker_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SETTLE = DEF_SETTLE,
    parameter int ERR_W  = DEF_ERR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [WIDTH-1:0]   A,
    output logic [WIDTH-1:0]   B,
    output logic               Cin,
    input  logic [WIDTH-1:0]   S,
    input  logic               Cout,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic               first_fail_valid,
    output logic [2*WIDTH:0]   first_fail_vec
);

    localparam int VW    = vec_width(WIDTH);
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

    localparam logic [VW-1:0]    VEC_LAST = '1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_t           state;
    state_t           state_next;
    logic [VW-1:0]    vec;
    logic [CNT_W-1:0] cnt;
    logic [ERR_W-1:0] err_r;
    logic             ffv_r;
    logic [VW-1:0]    ffvec_r;

    logic             accept;
    logic             mismatch;
    logic [WIDTH-1:0] s_ref;
    logic             cout_ref;

    assign A   = vec[VW-1 -: WIDTH];
    assign B   = vec[WIDTH:1];
    assign Cin = vec[0];

    adder_ref_model #(
        .WIDTH (WIDTH)
    ) u_ref (
        .A        (A),
        .B        (B),
        .Cin      (Cin),
        .S_ref    (s_ref),
        .Cout_ref (cout_ref)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt == CNT_W'(1)) state_next = ST_CHECK;
            end
            ST_CHECK: begin
                // Termination by comparison so vec never wraps back to zero.
                state_next = (vec == VEC_LAST) ? ST_DONE : ST_WAIT;
            end
        endcase
    end

    // Output / strobe logic
    always_comb begin
        busy     = (state == ST_WAIT) || (state == ST_CHECK);
        done     = (state == ST_DONE);
        pass     = done && (err_r == '0);
        accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
        mismatch = (state == ST_CHECK) && ({Cout, S} != {cout_ref, s_ref});
    end

    assign err_count        = err_r;
    assign first_fail_valid = ffv_r;
    assign first_fail_vec   = ffvec_r;

    // Vector, settle counter and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec     <= '0;
            cnt     <= '0;
            err_r   <= '0;
            ffv_r   <= 1'b0;
            ffvec_r <= '0;
        end else if (accept) begin
            vec     <= '0;
            cnt     <= CNT_LOAD;
            err_r   <= '0;
            ffv_r   <= 1'b0;
            ffvec_r <= '0;
        end else begin
            case (state)
                ST_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        if (err_r != ERR_MAX) err_r <= err_r + ERR_W'(1);
                        if (!ffv_r) begin
                            ffv_r   <= 1'b1;
                            ffvec_r <= vec;
                        end
                    end
                    // Last vector stays on the outputs once the sweep ends.
                    if (vec != VEC_LAST) begin
                        vec <= vec + VW'(1);
                        cnt <= CNT_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
